uart_rx_sampler: RTL
====================

# uart_rx_sampler

Oversampling front end of the UART receiver. It synchronises the raw RX line, runs the per-bit edge counter and bit counter, and produces a majority-voted sample once per bit. It sits directly upstream of the receive de-serializer and the parity/stop checkers. The de-serializer captures `Sampled_bit` when `edgecount == Prescale-1`, so this block must have the voted bit stable before that edge.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `RX_IN`; legal range 1..3.
- `Clk`  in  1  oversampling clock.
- `Rst`  in  1  reset, asynchronous, active-low.
- `RX_IN`  in  1  raw serial line, asynchronous to `Clk`; idle high.
- `Prescale`  in  6  oversampling ratio; supported values 8, 16, 32.
- `Cnt_en`  in  1  counter enable from the RX FSM; high for the whole frame.
- `Dat_samp_en`  in  1  sampling enable from the RX FSM.
- `RX_sync`  out  1  synchronised line, fed to the FSM for start detection.
- `edgecount`  out  6  oversample index within the current bit, 0..Prescale-1.
- `bitcount`  out  4  index of the current bit within the frame.
- `Sampled_bit`  out  1  majority-voted value of the current bit.
- `Sample_valid`  out  1  one-cycle pulse in the cycle `Sampled_bit` takes a new value.

## Operation
- **Synchroniser:**
  - Shift chain of `SYNC_STAGES` flops clocked by `Clk`.
  - All stages reset to 1.
  - `RX_sync` is the last stage.
- **Edge/bit counter:**
  - When `Cnt_en` = 0: next `edgecount` = 0 and next `bitcount` = 0.
  - When `Cnt_en` = 1 and `edgecount >= Prescale-1`: `edgecount` goes to 0 and `bitcount` increments.
    - `bitcount` saturates at 15; it never wraps.
    - The `>=` comparison makes the counter recover if `Prescale` was lowered below the current count.
  - Otherwise, when `Cnt_en` = 1: `edgecount` increments.
  - `Cnt_en` = 0 has priority over every other condition.
- **Sample points:**
  - `mid = Prescale >> 1`, a 5-bit logical shift.
  - While `Cnt_en` and `Dat_samp_en` are both high, `RX_sync` is captured into s0, s1, s2 at `edgecount == mid-1`, `mid`, `mid+1` respectively.
- **Vote:**
  - At `edgecount == mid+2`, with both enables high: `Sampled_bit` ← majority(s0, s1, s2), and `Sample_valid` = 1 in the cycle after that edge.
  - Sample registers reset to 1.
- **Sampling disabled** (`Dat_samp_en` = 0):
  - s0, s1, s2 and `Sampled_bit` hold their values.
  - `Sample_valid` = 0.
  - Counters are unaffected.
- **Reset values:**
  - `RX_sync` = 1, `edgecount` = 0, `bitcount` = 0, `Sampled_bit` = 1, `Sample_valid` = 0.
  - Sync stages and s0..s2 = 1.
- **`Prescale` usage:**
  - `Prescale` must only change while `Cnt_en` = 0.
  - Values below 8 are unsupported; the outputs are then don't-care, but the block must not lock up.
- **Reset mid-frame:** assertion forces all registers to their reset values immediately. After release, counting restarts only when `Cnt_en` is high.

## Timing
- `RX_IN` to `RX_sync`: `SYNC_STAGES` cycles.
- Counters update on `posedge Clk`. `edgecount` = 0 in the first cycle after `Cnt_en` rises, and counts 1, 2, … on the following edges.
- Vote register updates at the edge ending `edgecount == mid+2`. It is stable from `edgecount == mid+3` through the de-serializer capture at `Prescale-1`.
  - Prescale = 8: samples at 3, 4, 5; vote at 6; capture at 7. This gives a one-cycle margin.
- `Sample_valid` occurs once per bit period while sampling is enabled; it is never asserted for two consecutive cycles.
- `Cnt_en` falling on the same edge as a wrap: counters go to 0 and no increment of `bitcount` occurs.
- No combinational path from any input to any output.

## Test plan
- **Reset:**
  - Stimulus: assert `Rst` with `RX_IN` = 0 toggling.
  - Required: `RX_sync` = 1, `edgecount` = 0, `bitcount` = 0, `Sampled_bit` = 1, `Sample_valid` = 0. On release, `RX_sync` follows `RX_IN` after 2 cycles (default parameter).
- **Counting at Prescale = 8:**
  - Stimulus: `Cnt_en` = 1 for 30 cycles.
  - Required: `edgecount` sequence 0..7 repeating; `bitcount` 0 → 1 → 2 → 3 at each wrap; both counters 0 one cycle after `Cnt_en` drops.
- **Majority vote:**
  - Stimulus: Prescale = 16; drive `RX_sync` so the samples at `edgecount` 7, 8, 9 are 1, 0, 1.
  - Required: `Sampled_bit` = 1 with `Sample_valid` seen at `edgecount` 11. Pattern 0, 1, 0 yields `Sampled_bit` = 0.
- **Full frame:**
  - Stimulus: Prescale = 32; send byte 0xA5 (LSB first) plus start and stop.
  - Required: 10 `Sample_valid` pulses, each 32 cycles apart; voted bits 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
- **Sampling disabled:**
  - Stimulus: `Dat_samp_en` = 0 for one bit while the line changes.
  - Required: `Sampled_bit` holds and there is no `Sample_valid` pulse; `edgecount` keeps counting.
- **Abort and saturation:**
  - Stimulus: async `Rst` at `edgecount` = 5 mid-frame; separately, `Cnt_en` held high for 20 bit periods.
  - Required: immediate reset values on `Rst`; `bitcount` stops at 15 without wrapping.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: bundles the RX line, FSM controls and sampler outputs
interface uart_rx_sampler_if;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       Cnt_en;
  logic       Dat_samp_en;
  logic       RX_sync;
  logic [5:0] edgecount;
  logic [3:0] bitcount;
  logic       Sampled_bit;
  logic       Sample_valid;
  modport master (
    output RX_IN, Prescale, Cnt_en, Dat_samp_en,
    input  RX_sync, edgecount, bitcount, Sampled_bit, Sample_valid
  );
  modport slave (
    input  RX_IN, Prescale, Cnt_en, Dat_samp_en,
    output RX_sync, edgecount, bitcount, Sampled_bit, Sample_valid
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises RX, counts oversample edges and bits, majority-votes each bit
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input logic              Clk,
  input logic              Rst,
  uart_rx_sampler_if.slave bus
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [5:0] edge_q, mid, last;
  logic [3:0] bit_q;
  logic [2:0] samp_q;
  logic voted_q, valid_q, en, wrap, rx_s, maj;
  assign mid  = {1'b0, bus.Prescale[5:1]};
  assign last = bus.Prescale - 6'd1;
  assign wrap = edge_q >= last;
  assign en   = bus.Cnt_en & bus.Dat_samp_en;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  // synchroniser chain, idle-high so a reset never looks like a start bit
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) sync_q <= '1;
    else sync_q <= SYNC_STAGES'({sync_q, bus.RX_IN});
  // edge/bit counters; >= lets the edge counter recover from an out-of-range count
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (!bus.Cnt_en) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (wrap) begin
      edge_q <= '0;
      bit_q  <= bit_q + {3'd0, bit_q != 4'hf};
    end else edge_q <= edge_q + 6'd1;
  // three mid-bit samples, then a registered vote two edges after the centre
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      samp_q  <= '1;
      voted_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      samp_q[0] <= en && edge_q == mid - 6'd1 ? rx_s : samp_q[0];
      samp_q[1] <= en && edge_q == mid ? rx_s : samp_q[1];
      samp_q[2] <= en && edge_q == mid + 6'd1 ? rx_s : samp_q[2];
      voted_q   <= en && edge_q == mid + 6'd2 ? maj : voted_q;
      valid_q   <= en && edge_q == mid + 6'd2;
    end
  assign bus.RX_sync      = rx_s;
  assign bus.edgecount    = edge_q;
  assign bus.bitcount     = bit_q;
  assign bus.Sampled_bit  = voted_q;
  assign bus.Sample_valid = valid_q;
endmodule
